// File: rtl/byte_access_ctrl.sv
// Byte/word load-store sequencer onto a word-wide memory port (byte store = read-modify-write).
// Latency req->done: 3 cycles word/byte load and word store, 4 cycles byte store, +1 per memory wait cycle.
// Backpressure: requests only sampled in IDLE; memory stalls via mem_ack. Optional BYTE_SIGN_EXT_EN adds sx.
module byte_access_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             we,
    input  logic             bsel,
    input  logic [WIDTH-1:0] addr,
    input  logic [1:0]       byte_idx,
    input  logic [WIDTH-1:0] wdata,
`ifdef BYTE_SIGN_EXT_EN
    input  logic             sx,
`endif
    output logic [WIDTH-1:0] rdata,
    output logic             done,
    output logic             busy,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_wen,
    output logic             mem_req,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       state;
    logic             we_q;
    logic             bsel_q;
    logic [1:0]       idx_q;
    logic [7:0]       wbyte_q;
    logic             sx_q;
    logic [7:0]       lane;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] load_val;

`ifdef BYTE_SIGN_EXT_EN
    logic sx_in;
    assign sx_in = sx;
`else
    logic sx_in;
    assign sx_in = 1'b0;
`endif

    // Lane k lives at bits [8k+7:8k]; index kept 5 bits wide so it cannot wrap.
    always_comb begin
        lane   = mem_rdata[{idx_q, 3'b000} +: 8];
        merged = mem_rdata;
        merged[{idx_q, 3'b000} +: 8] = wbyte_q;
        if (!bsel_q)
            load_val = mem_rdata;
        else if (sx_q && lane[7])
            load_val = {{(WIDTH-8){1'b1}}, lane};
        else
            load_val = {{(WIDTH-8){1'b0}}, lane};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            bsel_q    <= 1'b0;
            idx_q     <= 2'd0;
            wbyte_q   <= 8'd0;
            sx_q      <= 1'b0;
            rdata     <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wen   <= 1'b0;
            mem_req   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        we_q     <= we;
                        bsel_q   <= bsel;
                        idx_q    <= byte_idx;
                        wbyte_q  <= wdata[7:0];
                        sx_q     <= sx_in;
                        busy     <= 1'b1;
                        mem_addr <= addr;
                        mem_req  <= 1'b1;
                        if (we && !bsel) begin
                            mem_wdata <= wdata;
                            mem_wen   <= 1'b1;
                            state     <= S_WR;
                        end else begin
                            mem_wen <= 1'b0;
                            state   <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ack) begin
                        if (we_q) begin
                            // mem_req stays high: the write follows the read with no gap.
                            mem_wdata <= merged;
                            mem_wen   <= 1'b1;
                            state     <= S_WR;
                        end else begin
                            rdata   <= load_val;
                            mem_req <= 1'b0;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_WR: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_wen <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/byte_access_ctrl.md
# byte_access_ctrl

Multi-cycle controller that sequences byte-granular loads and stores from the CPU onto the word-wide memory port. Byte loads are one word read followed by lane extraction, with zero- or sign-extension. Byte stores are a read-modify-write: read the word, merge the byte into the selected lane, write the word back. Word accesses pass through as a single transaction. The block sits between the CPU execute stage and the memory interface and owns the memory port for the whole duration of an access.

## Interface
- WIDTH, 32, data and address width; byte lanes are fixed at 4, so WIDTH must be 32.

- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  CPU access request; sampled only in IDLE.
- we  in  1  1 = store, 0 = load.
- bsel  in  1  1 = byte access, 0 = word access.
- addr  in  WIDTH  word address.
- byte_idx  in  2  lane select; 0 = bits 7:0 … 3 = bits 31:24.
- wdata  in  WIDTH  store data; a byte store uses bits 7:0.
- rdata  out  WIDTH  load result, registered; valid while done=1.
- done  out  1  one-cycle completion pulse.
- busy  out  1  high from request acceptance until done.
- mem_addr  out  WIDTH  memory word address.
- mem_wdata  out  WIDTH  memory write data.
- mem_wen  out  1  write enable, qualified by mem_req.
- mem_req  out  1  memory request.
- mem_ack  in  1  memory acknowledge; mem_rdata is valid in the same cycle.
- mem_rdata  in  WIDTH  memory read data.

## Operation
- States:
  - IDLE: waiting for a request.
  - RD: memory read in progress.
  - WR: memory write in progress.
  - DONE: one-cycle completion.
- IDLE with req=1:
  - Latch addr, byte_idx, wdata, we, bsel.
  - Go to WR if the access is a word store (we=1, bsel=0); otherwise go to RD.
- RD: mem_req=1, mem_wen=0, mem_addr=latched addr. On mem_ack:
  - Word load: rdata ← mem_rdata, go to DONE.
  - Byte load: rdata ← {24'b0, lane[byte_idx]} (extension per Configuration), go to DONE.
  - Byte store: latch the merged word (mem_rdata with lane byte_idx replaced by wdata[7:0]), go to WR.
- WR: mem_req=1, mem_wen=1.
  - mem_wdata = latched wdata for a word store; the merged word for a byte store.
  - On mem_ack go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- Stores leave rdata unchanged.
- Merge rule: lane k occupies bits [8k+7:8k]; all other lanes pass through unmodified.
- req arriving while busy=1 is ignored. The CPU holds req until it sees done.

## Timing
- Reset (reset=0 at a clock edge):
  - State → IDLE.
  - rdata=0, done=0, busy=0, mem_req=0, mem_wen=0, mem_addr=0, mem_wdata=0.
- Reset mid-access aborts the access. mem_req is low from the next edge, and no done is issued.
- busy rises on the edge that accepts req and falls on the edge leaving DONE.
- mem_req, mem_wen, mem_addr and mem_wdata are registered and held stable until the cycle in which mem_ack=1.
- mem_ack seen in IDLE or DONE is ignored.
- Latency from req acceptance to done, with zero-wait memory (mem_ack in the first request cycle):
  - Word load / word store: 3 cycles.
  - Byte load: 3 cycles.
  - Byte store: 4 cycles.
- Each memory wait cycle adds 1 cycle.
- Back-to-back: a new req is accepted no earlier than the cycle after done.
- The RD→WR transition of a byte store drops mem_req for no cycles. The write begins on the edge after the read ack, so mem_req stays high across the boundary.

## Configuration
- BYTE_SIGN_EXT_EN defined:
  - Byte loads sign-extend: rdata[31:8] = replicated bit 7 of the selected lane.
  - Adds input sx (in, 1), latched at request acceptance. sx=0 still zero-extends.
- BYTE_SIGN_EXT_EN undefined: the sx port is absent and byte loads always zero-extend.
- Word accesses are identical in both builds.

## Test plan
- Byte load, lane 2:
  - Stimulus: memory word 0x11A2B3C4 at addr 0x10, byte_idx=2, zero-wait memory.
  - Required: done on cycle 3 with rdata=0x000000A2; with BYTE_SIGN_EXT_EN and sx=1, rdata=0xFFFFFFA2.
- Byte store, lane 1:
  - Stimulus: memory word 0x11223344, wdata=0x000000EE, byte_idx=1.
  - Required: one read, then one write with mem_wdata=0x1122EE44; done on cycle 4; rdata unchanged.
- Word store with 2 wait cycles on mem_ack:
  - Stimulus: wdata=0xDEADBEEF.
  - Required: no read cycle; mem_wdata=0xDEADBEEF held for 3 cycles; done on cycle 5.
- Reset mid-access:
  - Stimulus: reset=0 during the WR state of a byte store.
  - Required: next cycle mem_req=0, busy=0, done=0, rdata=0; no write completes.
- req while busy:
  - Stimulus: second req pulses during RD.
  - Required: ignored; exactly one done issued.
- All lanes:
  - Stimulus: byte stores to lanes 0..3 of 0x00000000 with data 0x01..0x04, then a word load.
  - Required: rdata=0x04030201.
